// File: rtl/sdram_port_arbiter_pkg.sv
// Shared definitions for the two-port SDRAM arbiter and its clients (the cache
// reuses SDRAM_BURSTLEN). The command bundle's address width follows SDRAM_ADDRBITS.
package sdram_port_arbiter_pkg;

    localparam int SDRAM_BURSTLEN = 8;
    localparam int SDRAM_ADDRBITS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        BURST = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                      rw;
        logic [SDRAM_ADDRBITS-1:0] addr;
        logic [15:0]               wdata;
    } sdram_cmd_t;

    // A read of address 0 is the idle command seen by the controller.
    localparam sdram_cmd_t SDRAM_CMD_RESET = '{rw: 1'b1, addr: '0, wdata: '0};

    function automatic sdram_cmd_t make_cmd(
        input logic                      rw,
        input logic [SDRAM_ADDRBITS-1:0] addr,
        input logic [15:0]               wdata
    );
        sdram_cmd_t c;
        c.rw    = rw;
        c.addr  = addr;
        c.wdata = wdata;
        return c;
    endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner select for two requesters (0 = port 0, 1 = port 1).
// SDRAM_ARB_ROUNDROBIN_EN selects round-robin ties; otherwise port 0 wins ties.
module sdram_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic win
);

`ifdef SDRAM_ARB_ROUNDROBIN_EN
    always_comb begin
        // NOTE: give every always_comb output a default first so no path can infer a latch.
        win = 1'b0;
        if (req0 && req1)
            win = ~last_gnt;
        else
            win = req1;
    end
`else
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;

    always_comb begin
        win = req1 && !req0;
    end
`endif

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one 16-bit burst SDRAM controller port between two requesters.
// Tie policy is selected by SDRAM_ARB_ROUNDROBIN_EN (undefined: port 0 wins ties).
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int BURSTLEN = SDRAM_BURSTLEN,
    parameter int ADDRBITS = SDRAM_ADDRBITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0,
    input  logic                req1,
    input  logic                rw0,
    input  logic                rw1,
    input  logic [ADDRBITS-1:0] addr0,
    input  logic [ADDRBITS-1:0] addr1,
    input  logic [15:0]         wdata0,
    input  logic [15:0]         wdata1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                fill0,
    output logic                fill1,
    output logic                ack0,
    output logic                ack1,
    output logic                sdram_req,
    output logic                sdram_rw,
    output logic [ADDRBITS-1:0] sdram_addr,
    output logic [15:0]         sdram_wdata,
    input  logic                sdram_ack,
    input  logic                sdram_fill,
    output logic                busy,
    output logic                protocol_err
);

    localparam int                BEAT_W    = $clog2(BURSTLEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURSTLEN - 1);

    arb_state_t        state;
    sdram_cmd_t        cmd_q;
    sdram_cmd_t        cand;
    logic [BEAT_W-1:0] beat;
    logic              win;
    logic              last_gnt;
    logic              any_req;

    assign any_req = req0 || req1;

    sdram_arb_pick u_pick (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt),
        .win      (win)
    );

    assign cand = win ? make_cmd(rw1, addr1, wdata1) : make_cmd(rw0, addr0, wdata0);

`ifdef SDRAM_ARB_ROUNDROBIN_EN
    // Starts at 1 so port 0 takes the first tie after reset.
    always_ff @(posedge clk) begin
        if (!reset)
            last_gnt <= 1'b1;
        else if (state == IDLE && any_req)
            last_gnt <= win;
    end
`else
    assign last_gnt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!reset) begin
            state     <= IDLE;
            cmd_q     <= SDRAM_CMD_RESET;
            beat      <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            sdram_req <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        cmd_q     <= cand;
                        gnt0      <= ~win;
                        gnt1      <= win;
                        sdram_req <= 1'b1;
                        state     <= CMD;
                    end
                end
                CMD: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        if (cmd_q.rw) begin
                            beat  <= '0;
                            state <= BURST;
                        end else begin
                            ack0  <= gnt0;
                            ack1  <= gnt1;
                            gnt0  <= 1'b0;
                            gnt1  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                BURST: begin
                    if (sdram_fill) begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            gnt0  <= 1'b0;
                            gnt1  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sdram_rw    = cmd_q.rw;
    assign sdram_addr  = cmd_q.addr;
    assign sdram_wdata = cmd_q.wdata;
    assign busy        = (state != IDLE);

    // Fill is forwarded with no latency, and only while a burst is actually owed.
    assign fill0 = sdram_fill && (state == BURST) && gnt0;
    assign fill1 = sdram_fill && (state == BURST) && gnt1;

    assign protocol_err = (sdram_fill && (state != BURST)) || (sdram_ack && (state != CMD));

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a vector table plus multi-cycle sequences.
module tb_sdram_port_arbiter;

`ifdef SDRAM_ARB_ROUNDROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic gnt0, gnt1, fill0, fill1, ack0, ack1;
        logic sdram_req, sdram_rw, busy, protocol_err;
        logic [31:0] addr;
        logic [15:0] wdata;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic        req0, rw0;
        logic [31:0] addr0;
        logic [15:0] wdata0;
        logic        req1, rw1;
        logic [31:0] addr1;
        logic [15:0] wdata1;
        logic        ack, fill;
        out_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, rw0 = 1'b0, rw1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        sdram_ack = 1'b0, sdram_fill = 1'b0;
    logic        gnt0, gnt1, fill0, fill1, ack0, ack1;
    logic        sdram_req, sdram_rw, busy, protocol_err;
    logic [31:0] sdram_addr;
    logic [15:0] sdram_wdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.BURSTLEN(8), .ADDRBITS(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (req0),
        .req1         (req1),
        .rw0          (rw0),
        .rw1          (rw1),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .fill0        (fill0),
        .fill1        (fill1),
        .ack0         (ack0),
        .ack1         (ack1),
        .sdram_req    (sdram_req),
        .sdram_rw     (sdram_rw),
        .sdram_addr   (sdram_addr),
        .sdram_wdata  (sdram_wdata),
        .sdram_ack    (sdram_ack),
        .sdram_fill   (sdram_fill),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic out_t o(input logic g0, g1, f0, f1, a0, a1, rq, rw, bz, pe,
                               input logic [31:0] ad, input logic [15:0] wd);
        out_t r;
        r.gnt0 = g0; r.gnt1 = g1; r.fill0 = f0; r.fill1 = f1; r.ack0 = a0; r.ack1 = a1;
        r.sdram_req = rq; r.sdram_rw = rw; r.busy = bz; r.protocol_err = pe;
        r.addr = ad; r.wdata = wd;
        return r;
    endfunction

    function automatic vec_t v(input logic rst, q0, w0, input logic [31:0] a0, input logic [15:0] d0,
                               input logic q1, w1, input logic [31:0] a1, input logic [15:0] d1,
                               input logic ak, fl, input out_t e);
        vec_t r;
        r.rst = rst; r.req0 = q0; r.rw0 = w0; r.addr0 = a0; r.wdata0 = d0;
        r.req1 = q1; r.rw1 = w1; r.addr1 = a1; r.wdata1 = d1;
        r.ack = ak; r.fill = fl; r.exp = e;
        return r;
    endfunction

    function automatic out_t cur();
        return o(gnt0, gnt1, fill0, fill1, ack0, ack1, sdram_req, sdram_rw, busy, protocol_err,
                 sdram_addr, sdram_wdata);
    endfunction

    task automatic expect_out(input string name, input out_t e);
        check(name, 64'(cur()), 64'(e));
    endtask

    vec_t vecs[15];

    initial begin
        int f0, f1, pe;
        logic [1:0] exp_g;

        // Reset, stray strobes in IDLE, a port-1 write, then a port-0 write with a stray fill in CMD.
        vecs[0]  = v(0, 0,0,0,0,             0,0,0,0,             0,0, o(0,0,0,0,0,0,0,1,0,0,32'h0,16'h0));
        vecs[1]  = v(1, 0,0,0,0,             0,0,0,0,             0,0, o(0,0,0,0,0,0,0,1,0,0,32'h0,16'h0));
        vecs[2]  = v(1, 0,0,0,0,             0,0,0,0,             0,1, o(0,0,0,0,0,0,0,1,0,1,32'h0,16'h0));
        vecs[3]  = v(1, 0,0,0,0,             0,0,0,0,             0,0, o(0,0,0,0,0,0,0,1,0,0,32'h0,16'h0));
        vecs[4]  = v(1, 0,0,0,0,             0,0,0,0,             1,0, o(0,0,0,0,0,0,0,1,0,1,32'h0,16'h0));
        vecs[5]  = v(1, 0,0,0,0,             1,0,32'h55,16'hBEEF, 0,0, o(0,0,0,0,0,0,0,1,0,0,32'h0,16'h0));
        vecs[6]  = v(1, 0,0,0,0,             1,0,32'h55,16'hBEEF, 0,0, o(0,1,0,0,0,0,1,0,1,0,32'h55,16'hBEEF));
        vecs[7]  = v(1, 0,0,0,0,             1,0,32'h55,16'hBEEF, 1,0, o(0,1,0,0,0,0,1,0,1,0,32'h55,16'hBEEF));
        vecs[8]  = v(1, 0,0,0,0,             0,0,0,0,             0,0, o(0,0,0,0,0,1,0,0,0,0,32'h55,16'hBEEF));
        vecs[9]  = v(1, 0,0,0,0,             0,0,0,0,             0,0, o(0,0,0,0,0,0,0,0,0,0,32'h55,16'hBEEF));
        vecs[10] = v(1, 1,0,32'hA0,16'h1234, 0,0,0,0,             0,0, o(0,0,0,0,0,0,0,0,0,0,32'h55,16'hBEEF));
        vecs[11] = v(1, 1,0,32'hA0,16'h1234, 0,0,0,0,             0,1, o(1,0,0,0,0,0,1,0,1,1,32'hA0,16'h1234));
        vecs[12] = v(1, 1,0,32'hA0,16'h1234, 0,0,0,0,             1,0, o(1,0,0,0,0,0,1,0,1,0,32'hA0,16'h1234));
        vecs[13] = v(1, 0,0,0,0,             0,0,0,0,             0,0, o(0,0,0,0,1,0,0,0,0,0,32'hA0,16'h1234));
        vecs[14] = v(1, 0,0,0,0,             0,0,0,0,             0,0, o(0,0,0,0,0,0,0,0,0,0,32'hA0,16'h1234));

        repeat (2) @(posedge clk);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            reset = vecs[i].rst;
            req0 = vecs[i].req0; rw0 = vecs[i].rw0; addr0 = vecs[i].addr0; wdata0 = vecs[i].wdata0;
            req1 = vecs[i].req1; rw1 = vecs[i].rw1; addr1 = vecs[i].addr1; wdata1 = vecs[i].wdata1;
            sdram_ack = vecs[i].ack; sdram_fill = vecs[i].fill;
            #1 expect_out($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Single read on port 0, ack three cycles after request, one stray ack mid-burst.
        @(negedge clk); req0 = 1; rw0 = 1; addr0 = 32'h0000_1230; wdata0 = 16'h0;
        @(negedge clk); #1 expect_out("rd_grant", o(1,0,0,0,0,0,1,1,1,0,32'h1230,16'h0));
        @(negedge clk); #1 expect_out("rd_wait",  o(1,0,0,0,0,0,1,1,1,0,32'h1230,16'h0));
        @(negedge clk); sdram_ack = 1;
        #1 expect_out("rd_ack", o(1,0,0,0,0,0,1,1,1,0,32'h1230,16'h0));
        f0 = 0; f1 = 0;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            sdram_ack = (b == 4);
            sdram_fill = 1;
            if (b == 7) req0 = 0;
            #1 expect_out($sformatf("rd_beat%0d", b), o(1,0,1,0,0,0,0,1,1,(b == 4),32'h1230,16'h0));
            f0 += int'(fill0); f1 += int'(fill1);
        end
        @(negedge clk); sdram_fill = 0; sdram_ack = 0;
        #1 expect_out("rd_done", o(0,0,0,0,0,0,0,1,0,0,32'h1230,16'h0));
        check("rd_fill0_count", 64'(f0), 64'd8);
        check("rd_fill1_count", 64'(f1), 64'd0);

        // Port 0 drops its request while in CMD; the read still completes.
        @(negedge clk); req0 = 1; rw0 = 1; addr0 = 32'h0000_2000;
        @(negedge clk); req0 = 0;
        #1 expect_out("wd_grant", o(1,0,0,0,0,0,1,1,1,0,32'h2000,16'h0));
        @(negedge clk); sdram_ack = 1;
        #1 expect_out("wd_ack", o(1,0,0,0,0,0,1,1,1,0,32'h2000,16'h0));
        f0 = 0; pe = 0;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk); sdram_ack = 0; sdram_fill = 1;
            #1 f0 += int'(fill0); pe += int'(protocol_err);
        end
        @(negedge clk); sdram_fill = 0;
        #1 expect_out("wd_done", o(0,0,0,0,0,0,0,1,0,0,32'h2000,16'h0));
        check("wd_fill0_count", 64'(f0), 64'd8);
        check("wd_perr_count", 64'(pe), 64'd0);

        // Reset asserted in the cycle after fill beat 3.
        @(negedge clk); req0 = 1; rw0 = 1; addr0 = 32'h0000_3000;
        @(negedge clk);
        @(negedge clk); sdram_ack = 1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk); sdram_ack = 0; sdram_fill = 1;
            #1 expect_out($sformatf("rst_beat%0d", b), o(1,0,1,0,0,0,0,1,1,0,32'h3000,16'h0));
        end
        @(negedge clk); reset = 0; req0 = 0;
        #1 expect_out("rst_assert", o(1,0,1,0,0,0,0,1,1,0,32'h3000,16'h0));
        for (int b = 4; b < 8; b++) begin
            @(negedge clk); reset = 1;
            #1 expect_out($sformatf("rst_stray%0d", b), o(0,0,0,0,0,0,0,1,0,1,32'h0,16'h0));
        end
        @(negedge clk); sdram_fill = 0;
        #1 expect_out("rst_idle", o(0,0,0,0,0,0,0,1,0,0,32'h0,16'h0));

        // Repeated ties: both ports raise together in IDLE, each round is a write.
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            req0 = 1; rw0 = 0; addr0 = 32'h100 + 32'(r); wdata0 = 16'hA000 + 16'(r);
            req1 = 1; rw1 = 0; addr1 = 32'h200 + 32'(r); wdata1 = 16'hB000 + 16'(r);
            #1 check($sformatf("tie%0d_idle", r), {62'd0, busy, ack0 | ack1}, 64'd0);
            exp_g = (RR && (r % 2 == 1)) ? 2'b01 : 2'b10;
            @(negedge clk); req0 = 0; req1 = 0;
            #1 check($sformatf("tie%0d_gnt", r), 64'({gnt0, gnt1}), 64'(exp_g));
            check($sformatf("tie%0d_addr", r), 64'(sdram_addr),
                  exp_g[1] ? 64'(32'h100 + 32'(r)) : 64'(32'h200 + 32'(r)));
            @(negedge clk); sdram_ack = 1;
            @(negedge clk); sdram_ack = 0;
            #1 check($sformatf("tie%0d_ack", r), 64'({ack0, ack1}), 64'(exp_g));
        end
        @(negedge clk);
        #1 check("tie_final_idle", 64'({gnt0, gnt1, ack0, ack1, busy}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
